// File: rtl/score_bcd_encoder.sv
// rtl/score_bcd_encoder.sv - 6-bit binary to two-digit BCD score encoder (shift-and-add-3)
module score_bcd_encoder (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [5:0] value,
  output logic       busy,
  output logic       done,
  output logic       valid,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       over
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Scores above this threshold are reported as bust / out of range.
  localparam logic [5:0] OVER_LIMIT = 6'd34;
  // The last shift happens when the counter still reads 5 (six shifts: 0..5).
  localparam logic [2:0] LAST_SHIFT = 3'd5;

  state_t     state;
  logic [5:0] shreg;
  logic [7:0] scratch;
  logic [2:0] cnt;
  logic       over_cap;

  logic [7:0] adj;
  logic [7:0] scratch_next;
  logic [5:0] shreg_next;

  // One double-dabble step: add 3 to any nibble >= 5, then shift {scratch, shreg} left.
  always_comb begin
    adj = scratch;
    if (scratch[3:0] >= 4'd5) adj[3:0] = scratch[3:0] + 4'd3;
    if (scratch[7:4] >= 4'd5) adj[7:4] = scratch[7:4] + 4'd3;
    scratch_next = {adj[6:0], shreg[5]};
    shreg_next   = {shreg[4:0], 1'b0};
  end

  // Control FSM with registered outputs; results land on the edge entering DONE
  // so the new digits and the done pulse are visible in the same cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      shreg    <= 6'd0;
      scratch  <= 8'd0;
      cnt      <= 3'd0;
      over_cap <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      valid    <= 1'b0;
      tens     <= 4'd0;
      ones     <= 4'd0;
      over     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shreg    <= value;
            scratch  <= 8'd0;
            cnt      <= 3'd0;
            over_cap <= (value > OVER_LIMIT);
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          shreg   <= shreg_next;
          scratch <= scratch_next;
          cnt     <= cnt + 3'd1;
          if (cnt == LAST_SHIFT) begin
            tens  <= scratch_next[7:4];
            ones  <= scratch_next[3:0];
            over  <= over_cap;
            valid <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
